// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store unit acting as initiator of a word-wide data
// memory port (combinational read, write on the clock edge).
// Byte/halfword/word loads and stores arrive over a valid/ready handshake.
// Sub-word stores are done as read-modify-write. Load data is extracted and
// sign- or zero-extended. Each accepted request gets exactly one response.
// Optional feature: define LSU_PERF_CNT_EN to build the load/store/error
// completion counters. Without it, cnt_*_o are tied to zero.
module lsu_mem_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_signed_i,
  input  logic [ADDR_WIDTH+1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [31:0]           cnt_load_o,
  output logic [31:0]           cnt_store_o,
  output logic [31:0]           cnt_err_o
);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Illegal size code or an address not aligned to the access size.
  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Select the addressed byte/halfword lane and extend it to a full word.
  function automatic logic [DATA_WIDTH-1:0] load_extract(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            size,
    input logic [1:0]            off,
    input logic                  sgn
  );
    logic [DATA_WIDTH-1:0] byte_sh;
    logic [DATA_WIDTH-1:0] half_sh;
    logic [DATA_WIDTH-1:0] res;
    byte_sh = word >> {off, 3'b000};
    half_sh = word >> {off[1], 4'b0000};
    case (size)
      SZ_B:    res = {{(DATA_WIDTH-8){sgn & byte_sh[7]}}, byte_sh[7:0]};
      SZ_H:    res = {{(DATA_WIDTH-16){sgn & half_sh[15]}}, half_sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed lane(s) of the old memory word with store data.
  function automatic logic [DATA_WIDTH-1:0] store_merge(
    input logic [DATA_WIDTH-1:0] word,
    input logic [15:0]           wdata,
    input logic [1:0]            size,
    input logic [1:0]            off
  );
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] data;
    case (size)
      SZ_B: begin
        mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << {off, 3'b000};
        data = {{(DATA_WIDTH-8){1'b0}}, wdata[7:0]} << {off, 3'b000};
      end
      SZ_H: begin
        mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << {off[1], 4'b0000};
        data = {{(DATA_WIDTH-16){1'b0}}, wdata} << {off[1], 4'b0000};
      end
      default: begin
        mask = '0;
        data = '0;
      end
    endcase
    return (word & ~mask) | (data & mask);
  endfunction

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic [1:0]              size_q, size_d;
  logic                    sgn_q, sgn_d;
  logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
  logic [15:0]             wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    mem_we_q, mem_we_d;

  // Next-state logic: request capture, memory read capture and write data build.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_wdata_d = '0;
    mem_we_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          sgn_d   = req_signed_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i[15:0];
          rdata_d = '0;
          if (req_illegal(req_size_i, req_addr_i[1:0])) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (req_we_i && (req_size_i == SZ_W)) begin
            // Full-word store needs no read of the old contents.
            err_d       = 1'b0;
            mem_wdata_d = req_wdata_i;
            mem_we_d    = 1'b1;
            state_d     = S_WR;
          end else begin
            err_d   = 1'b0;
            state_d = S_RD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (we_q) begin
          mem_wdata_d = store_merge(mem_rdata_i, wdata_q, size_q, addr_q[1:0]);
          mem_we_d    = 1'b1;
          state_d     = S_WR;
        end else begin
          rdata_d = load_extract(mem_rdata_i, size_q, addr_q[1:0], sgn_q);
          state_d = S_RESP;
        end
      end
      S_WR: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      sgn_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 16'h0000;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign mem_addr_o   = addr_q[ADDR_WIDTH+1:2];
  assign mem_wdata_o  = mem_wdata_q;
  // A reset arriving during the write cycle must cancel that write.
  assign mem_we_o     = mem_we_q & ~reset;

`ifdef LSU_PERF_CNT_EN
  logic        resp_hs_s;
  logic [31:0] cnt_load_q;
  logic [31:0] cnt_store_q;
  logic [31:0] cnt_err_q;

  assign resp_hs_s = resp_valid_o & resp_ready_i;

  // Completion counters, bumped on the response handshake by request kind.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_load_q  <= 32'h0000_0000;
      cnt_store_q <= 32'h0000_0000;
      cnt_err_q   <= 32'h0000_0000;
    end else if (resp_hs_s) begin
      if (err_q) begin
        cnt_err_q <= cnt_err_q + 32'h0000_0001;
      end else if (we_q) begin
        cnt_store_q <= cnt_store_q + 32'h0000_0001;
      end else begin
        cnt_load_q <= cnt_load_q + 32'h0000_0001;
      end
    end else begin
      cnt_load_q  <= cnt_load_q;
      cnt_store_q <= cnt_store_q;
      cnt_err_q   <= cnt_err_q;
    end
  end

  assign cnt_load_o  = cnt_load_q;
  assign cnt_store_o = cnt_store_q;
  assign cnt_err_o   = cnt_err_q;
`else
  assign cnt_load_o  = 32'h0000_0000;
  assign cnt_store_o = 32'h0000_0000;
  assign cnt_err_o   = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// Testbench for lsu_mem_master: directed scenarios followed by random
// traffic. The reference model keeps a byte-addressed shadow memory.
// Expected responses and expected memory writes go into queues, and a
// monitor process pops and compares them as the DUT presents them.
module tb_lsu_mem_master;

  logic        clock;
  logic        reset;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_signed_i;
  logic [9:0]  req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [7:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_we_o;
  logic [31:0] mem_rdata_i;
  logic [31:0] cnt_load_o;
  logic [31:0] cnt_store_o;
  logic [31:0] cnt_err_o;

  lsu_mem_master #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_signed_i(req_signed_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i),
    .cnt_load_o(cnt_load_o), .cnt_store_o(cnt_store_o), .cnt_err_o(cnt_err_o)
  );

  // Environment memory: combinational read, write on the clock edge.
  logic [31:0] tb_mem [256];
  assign mem_rdata_i = tb_mem[mem_addr_o];
  always @(posedge clock) begin
    if (mem_we_o) tb_mem[mem_addr_o] <= mem_wdata_o;
  end

  // Reference model state
  logic [7:0] ref_bytes [1024];
  typedef struct { bit err; logic [31:0] rdata; int acc; int lat; int kind; } exp_t;
  typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
  exp_t sb_q[$];
  wr_t  wq[$];
  int   mcnt_load, mcnt_store, mcnt_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 1;   // 0 random, 1 always ready, 2 hold off

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int base);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < 4; i++) w = w | (32'(ref_bytes[base + i]) << (8 * i));
    return w;
  endfunction

  // Model one accepted request: compute response, latency and memory write.
  task automatic model_push(input bit we, input logic [1:0] sz, input bit sg,
                            input logic [9:0] a, input logic [31:0] wd, input int acc);
    exp_t e;
    wr_t  w;
    int   nb;
    int   ai;
    logic [31:0] v;
    ai = int'(a);
    e.acc   = acc;
    e.err   = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    e.rdata = 32'h0;
    nb = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    if (e.err) begin
      e.lat = 1; e.kind = 2;
    end else if (we) begin
      e.lat = (nb == 4) ? 2 : 3; e.kind = 1;
      for (int i = 0; i < nb; i++) ref_bytes[ai + i] = 8'(wd >> (8 * i));
      w.a = a[9:2];
      w.d = ref_word(ai - (ai % 4));
      wq.push_back(w);
    end else begin
      e.lat = 2; e.kind = 0;
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[ai + i]) << (8 * i));
      if (sg && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      e.rdata = v;
    end
    sb_q.push_back(e);
  endtask

  task automatic issue(input bit we, input logic [1:0] sz, input bit sg,
                       input logic [9:0] a, input logic [31:0] wd);
    int n;
    n = 0;
    @(negedge clock);
    while (!req_ready_o && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready_o) begin
      chk(1'b0, "req_ready_timeout", {31'h0, req_ready_o}, 32'h1);
    end else begin
      req_we_i = we; req_size_i = sz; req_signed_i = sg; req_addr_i = a; req_wdata_i = wd;
      req_valid_i = 1'b1;
      @(posedge clock);
      #1;
      model_push(we, sz, sg, a, wd, cyc);
      @(negedge clock);
      req_valid_i = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || wq.size() != 0) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk(sb_q.size() == 0, "resp_drain", 32'(sb_q.size()), 32'h0);
    chk(wq.size() == 0, "write_drain", 32'(wq.size()), 32'h0);
    repeat (2) @(negedge clock);
  endtask

  task automatic check_cnt();
`ifdef LSU_PERF_CNT_EN
    chk(cnt_load_o == 32'(mcnt_load), "cnt_load", cnt_load_o, 32'(mcnt_load));
    chk(cnt_store_o == 32'(mcnt_store), "cnt_store", cnt_store_o, 32'(mcnt_store));
    chk(cnt_err_o == 32'(mcnt_err), "cnt_err", cnt_err_o, 32'(mcnt_err));
`else
    chk(cnt_load_o == 32'h0, "cnt_load_tied", cnt_load_o, 32'h0);
    chk(cnt_store_o == 32'h0, "cnt_store_tied", cnt_store_o, 32'h0);
    chk(cnt_err_o == 32'h0, "cnt_err_tied", cnt_err_o, 32'h0);
`endif
  endtask

  // Response-ready driver, changed just after each rising edge.
  initial begin
    resp_ready_i = 1'b1;
    forever begin
      @(posedge clock);
      #2;
      case (rdy_mode)
        0:       resp_ready_i = 1'($urandom_range(0, 1));
        1:       resp_ready_i = 1'b1;
        default: resp_ready_i = 1'b0;
      endcase
    end
  end

  // Monitor: memory writes, response latency/stability/data, return to idle.
  initial begin
    bit          in_resp;
    bit          hs_prev;
    logic [31:0] hold_rdata;
    logic        hold_err;
    exp_t        e;
    wr_t         w;
    in_resp = 1'b0;
    hs_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (mem_we_o) begin
        if (wq.size() == 0) begin
          chk(1'b0, "unexpected_write", {24'h0, mem_addr_o}, 32'h0);
        end else begin
          w = wq.pop_front();
          chk(mem_addr_o == w.a, "write_addr", {24'h0, mem_addr_o}, {24'h0, w.a});
          chk(mem_wdata_o == w.d, "write_data", mem_wdata_o, w.d);
        end
      end else begin
        chk(reset || mem_wdata_o == 32'h0, "wdata_idle_zero", mem_wdata_o, 32'h0);
      end
      if (hs_prev) begin
        chk(req_ready_o && !resp_valid_o, "idle_after_resp", {30'h0, req_ready_o, resp_valid_o}, 32'h2);
        hs_prev = 1'b0;
      end
      if (resp_valid_o) begin
        if (sb_q.size() == 0) begin
          chk(1'b0, "unexpected_resp", resp_rdata_o, 32'h0);
        end else begin
          e = sb_q[0];
          if (!in_resp) begin
            in_resp = 1'b1;
            chk(cyc - e.acc + 1 == e.lat, "resp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            hold_rdata = resp_rdata_o;
            hold_err = resp_err_o;
          end else begin
            chk(resp_rdata_o == hold_rdata && resp_err_o == hold_err, "resp_stable", resp_rdata_o, hold_rdata);
          end
          chk(!req_ready_o, "no_ready_in_resp", {31'h0, req_ready_o}, 32'h0);
          if (resp_ready_i) begin
            void'(sb_q.pop_front());
            chk(resp_err_o == e.err, "resp_err", {31'h0, resp_err_o}, {31'h0, e.err});
            chk(resp_rdata_o == e.rdata, "resp_rdata", resp_rdata_o, e.rdata);
            if (e.kind == 0) mcnt_load++;
            else if (e.kind == 1) mcnt_store++;
            else mcnt_err++;
            in_resp = 1'b0;
            hs_prev = 1'b1;
          end
        end
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    logic [31:0] w;
    logic [1:0]  sz;
    logic [9:0]  a;
    int          n;
    reset = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
    req_signed_i = 1'b0; req_addr_i = 10'h0; req_wdata_i = 32'h0;
    mcnt_load = 0; mcnt_store = 0; mcnt_err = 0;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      tb_mem[i] = w;
      for (int k = 0; k < 4; k++) ref_bytes[4 * i + k] = 8'(w >> (8 * k));
    end
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk(req_ready_o == 1'b1, "rst_req_ready", {31'h0, req_ready_o}, 32'h1);
    chk(resp_valid_o == 1'b0, "rst_resp_valid", {31'h0, resp_valid_o}, 32'h0);
    chk(resp_rdata_o == 32'h0, "rst_resp_rdata", resp_rdata_o, 32'h0);
    chk(resp_err_o == 1'b0, "rst_resp_err", {31'h0, resp_err_o}, 32'h0);
    chk(mem_we_o == 1'b0, "rst_mem_we", {31'h0, mem_we_o}, 32'h0);
    check_cnt();

    // Directed scenarios
    issue(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEAD_BEEF);
    issue(1'b0, 2'd2, 1'b0, 10'h010, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 10'h011, 32'h0000_0055);
    issue(1'b0, 2'd0, 1'b1, 10'h013, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 10'h013, 32'h0);
    issue(1'b0, 2'd1, 1'b1, 10'h012, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 10'h012, 32'h0);
    issue(1'b0, 2'd3, 1'b0, 10'h010, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 10'h021, 32'h0000_1234);
    drain();
    chk(tb_mem[4] == 32'hDEAD_55EF, "mem_word_0x10", tb_mem[4], 32'hDEAD_55EF);

    // Backpressure: hold the response off for five cycles during a load
    rdy_mode = 2;
    issue(1'b0, 2'd0, 1'b1, 10'h013, 32'h0);
    n = 0;
    while (!resp_valid_o && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk(resp_valid_o, "bp_resp_seen", {31'h0, resp_valid_o}, 32'h1);
    repeat (5) @(negedge clock);
    rdy_mode = 1;
    drain();

    // Reset during the write cycle of a byte store
    @(negedge clock);
    req_we_i = 1'b1; req_size_i = 2'd0; req_signed_i = 1'b0;
    req_addr_i = 10'h011; req_wdata_i = 32'h0000_00AA; req_valid_i = 1'b1;
    @(posedge clock);
    #1;
    req_valid_i = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk(mem_we_o == 1'b0, "rst_wr_mem_we", {31'h0, mem_we_o}, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    mcnt_load = 0; mcnt_store = 0; mcnt_err = 0;
    chk(req_ready_o == 1'b1, "rst_wr_req_ready", {31'h0, req_ready_o}, 32'h1);
    chk(resp_valid_o == 1'b0, "rst_wr_resp_valid", {31'h0, resp_valid_o}, 32'h0);
    chk(tb_mem[4] == ref_word(16), "rst_wr_mem_unchanged", tb_mem[4], ref_word(16));
    check_cnt();
    repeat (3) @(negedge clock);
    chk(resp_valid_o == 1'b0, "rst_wr_no_resp", {31'h0, resp_valid_o}, 32'h0);

    // Three loads and one error, then the counters
    issue(1'b0, 2'd2, 1'b0, 10'h010, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 10'h011, 32'h0);
    issue(1'b0, 2'd1, 1'b1, 10'h012, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 10'h011, 32'h0);
    drain();
    check_cnt();

    // Random traffic with random response backpressure
    rdy_mode = 0;
    for (int t = 0; t < 250; t++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = 10'($urandom_range(0, 1023));
      else a = 10'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end
    rdy_mode = 1;
    drain();
    check_cnt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
